garbage_tx: RTL and testbench

GARBAGE_TX -- requirements
Module: garbage_tx

---
 rtl/garbage_tx_pkg.sv | 40 ++++
 rtl/garbage_tx_if.sv | 11 +
 rtl/garbage_fifo.sv | 49 ++++
 rtl/garbage_tx.sv | 134 +++++++++++++
 tb/tb_garbage_tx.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/garbage_tx_pkg.sv
// Shared types and constant tables for the garbage (attack row) transmitter.
// The package name is fixed by the codebase; this file holds it.
package enum_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int ROW_W  = 5;
  localparam int HOLE_W = 4;
  localparam int COLS   = 10;

  // Base rows by lines cleared (index lines-1) and combo bonus by bucket.
  localparam logic [3:0][2:0] BASE_TBL  = {3'd4, 3'd2, 3'd1, 3'd0};
  localparam logic [3:0][1:0] BONUS_TBL = {2'd3, 2'd2, 2'd1, 2'd0};

  typedef struct packed {
    logic [ROW_W-1:0]  rows;
    logic [HOLE_W-1:0] hole;
  } batch_t;

  // Out-of-range line counts yield zero rows, so such a batch is never queued.
  function automatic logic [ROW_W-1:0] attack_rows(input logic [2:0] lines,
                                                   input logic [7:0] combo,
                                                   input logic       t_spin,
                                                   input logic [ROW_W-1:0] cap);
    logic [ROW_W-1:0] sum;
    logic [1:0]       bkt;
    sum = '0;
    bkt = (combo >= 8'd6) ? 2'd3 : combo[2:1];
    if (lines >= 3'd1 && lines <= 3'd4)
      sum = 5'(BASE_TBL[2'(lines - 3'd1)]) + (t_spin ? 5'(lines) : 5'd0)
          + 5'(BONUS_TBL[bkt]);
    if (sum > cap) sum = cap;
    return sum;
  endfunction

endpackage

// File: rtl/garbage_tx_if.sv
// Row-offer handshake towards the opponent core.
interface garbage_tx_if;
  import enum_type::*;

  logic            bar_req;
  logic [COLS-1:0] bar_mask;
  logic            bar_ack;

  modport master (output bar_req, output bar_mask, input bar_ack);
  modport slave  (input bar_req, input bar_mask, output bar_ack);
endinterface

// File: rtl/garbage_fifo.sv
// Batch FIFO; a write while full succeeds when a read happens in the same cycle.
module garbage_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr, do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/garbage_tx.sv
// Turns line clears into attack batches, queues them and offers rows one at a
// time to the opponent with a fixed idle gap between rows.
module garbage_tx
  import enum_type::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_ROWS   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       rng,
  input  logic              clear_valid,
  input  logic [2:0]        lines,
  input  logic [7:0]        combo_cnt,
  input  logic              t_spin,
  input  logic              flush,
  garbage_tx_if.master      bar,
  output logic [ROW_W-1:0]  pending_rows,
  output logic [7:0]        total_sent,
  output logic              dropped
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  state_t            state;
  logic              att_vld;
  batch_t            att, head, fifo_q;
  logic              fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [ROW_W-1:0]  row_cnt;
  logic [HOLE_W-1:0] hole;
  logic [GW-1:0]     gap_cnt;
  logic              xfer, pop, enq, fits, avail;
  logic [ROW_W-1:0]  pend_base, new_rows;
  logic [ROW_W:0]    pend_sum;
  logic [HOLE_W-1:0] new_hole;
  logic              unused_rng;

  assign unused_rng = ^rng[31:4];
  assign new_rows   = attack_rows(lines, combo_cnt, t_spin, 5'(MAX_ROWS));
  assign new_hole   = (rng[3:0] < 4'd10) ? rng[3:0] : rng[3:0] - 4'd10;

  // Attack stage: one register between the clear event and the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      att_vld <= 1'b0;
      att     <= '0;
    end else begin
      att_vld <= clear_valid && (new_rows != '0);
      att     <= '{rows: new_rows, hole: new_hole};
    end
  end

  // Admission is judged against the backlog after this cycle's transfer.
  assign xfer      = bar.bar_req && bar.bar_ack;
  assign pend_base = pending_rows - {4'd0, xfer};
  assign pend_sum  = {1'b0, pend_base} + {1'b0, att.rows};
  assign fits      = (pend_sum <= 6'(MAX_ROWS));

  // An empty FIFO is bypassed so a fresh batch can be popped in its arrival
  // cycle; this is what gives the two-cycle clear-to-offer latency.
  assign avail   = !fifo_empty || (att_vld && fits);
  assign pop     = (state == IDLE) && avail && !flush;
  assign enq     = att_vld && fits && (!fifo_full || pop) && !flush;
  assign head    = fifo_empty ? att : fifo_q;
  assign fifo_wr = enq && !(pop && fifo_empty);
  assign fifo_rd = pop && !fifo_empty;

  garbage_fifo #(.DEPTH(FIFO_DEPTH), .W(ROW_W + HOLE_W)) u_fifo (
    .clk     (clk),
    .clr     (reset || flush),
    .wr_en   (fifo_wr),
    .wr_data (att),
    .rd_en   (fifo_rd),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The drop rule keeps pending_rows at or below MAX_ROWS by construction.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state        <= IDLE;
      row_cnt      <= '0;
      hole         <= '0;
      gap_cnt      <= '0;
      bar.bar_req  <= 1'b0;
      bar.bar_mask <= '0;
      pending_rows <= '0;
      dropped      <= 1'b0;
    end else begin
      dropped      <= att_vld && !enq;
      pending_rows <= enq ? pend_sum[ROW_W-1:0] : pend_base;
      case (state)
        IDLE: if (pop) begin
          row_cnt      <= head.rows;
          hole         <= head.hole;
          bar.bar_req  <= 1'b1;
          bar.bar_mask <= 10'd1 << head.hole;
          state        <= SEND;
        end
        SEND: if (xfer) begin
          row_cnt      <= row_cnt - 5'd1;
          bar.bar_req  <= 1'b0;
          bar.bar_mask <= '0;
          gap_cnt      <= GAP_LOAD;
          state        <= GAP;
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (row_cnt != '0) begin
              bar.bar_req  <= 1'b1;
              bar.bar_mask <= 10'd1 << hole;
              state        <= SEND;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delivered-row count survives a flush, only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)
      total_sent <= '0;
    else if (!flush && xfer && total_sent != 8'hFF)
      total_sent <= total_sent + 8'd1;
  end
endmodule

// File: tb/tb_garbage_tx.sv
// Bench for garbage_tx: directed scenarios plus random traffic against a
// timestamp-based reference model of the row sender.
module tb_garbage_tx;
  localparam int DEPTH = 4;
  localparam int GAP   = 4;
  localparam int MAXR  = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rng;
  logic        clear_valid;
  logic [2:0]  lines;
  logic [7:0]  combo_cnt;
  logic        t_spin;
  logic        flush;
  logic [4:0]  pending_rows;
  logic [7:0]  total_sent;
  logic        dropped;

  garbage_tx_if bif();

  garbage_tx #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .MAX_ROWS(MAXR)) dut (
    .clk          (clk),
    .reset        (reset),
    .rng          (rng),
    .clear_valid  (clear_valid),
    .lines        (lines),
    .combo_cnt    (combo_cnt),
    .t_spin       (t_spin),
    .flush        (flush),
    .bar          (bif),
    .pending_rows (pending_rows),
    .total_sent   (total_sent),
    .dropped      (dropped)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: queue of batches plus the cycle numbers at which the
  // sender may next offer a row or pick up a new batch.
  typedef struct { int rows; int hole; } batch_s;
  batch_s q[$];
  int m_left, m_hole, m_pend, m_total, offer_at, free_at;
  bit m_req, m_drop, st_vld;
  int st_rows, st_hole;

  logic       l_req, l_drop;
  logic [9:0] l_mask;
  logic [4:0] l_pend;
  logic [7:0] l_total;

  function automatic int atk_rows(int ln, int cb, bit sp);
    int base, bonus, s;
    if (ln < 1 || ln > 4) return 0;
    base  = (ln == 4) ? 4 : ln - 1;
    bonus = (cb >= 6) ? 3 : cb / 2;
    s     = base + (sp ? ln : 0) + bonus;
    return (s > MAXR) ? MAXR : s;
  endfunction

  task automatic model_clear(bit keep_total);
    q.delete();
    m_left = 0; m_hole = 0; m_pend = 0; m_req = 0; m_drop = 0;
    st_vld = 0; st_rows = 0; st_hole = 0;
    offer_at = -1; free_at = 0;
    if (!keep_total) m_total = 0;
  endtask

  task automatic model_edge(int c);
    bit xfer, free;
    int pb;
    batch_s b;
    if (reset) begin model_clear(0); return; end
    if (flush) begin model_clear(1); return; end
    xfer = m_req && bif.bar_ack;
    pb   = m_pend - (xfer ? 1 : 0);
    if (xfer) begin
      if (m_total < 255) m_total++;
      m_left--;
      m_req = 0;
      if (m_left > 0) offer_at = c + GAP + 1;
      else            free_at  = c + GAP + 1;
    end
    free   = (m_left == 0) && (c >= free_at);
    m_drop = 0;
    if (st_vld) begin
      if (pb + st_rows > MAXR || (q.size() == DEPTH && !free)) m_drop = 1;
      else begin
        q.push_back('{st_rows, st_hole});
        pb += st_rows;
      end
    end
    if (free && q.size() > 0) begin
      b = q.pop_front();
      m_left = b.rows;
      m_hole = b.hole;
      offer_at = c + 1;
    end
    if (offer_at == c + 1) m_req = 1;
    m_pend  = pb;
    st_rows = atk_rows(int'(lines), int'(combo_cnt), t_spin);
    st_vld  = clear_valid && (st_rows > 0);
    st_hole = int'(rng[3:0]) % 10;
  endtask

  // One cycle: sample and check at negedge, advance model, cross posedge.
  task automatic step();
    @(negedge clk);
    l_req = bif.bar_req; l_mask = bif.bar_mask; l_pend = pending_rows;
    l_total = total_sent; l_drop = dropped;
    chk("bar_req",  32'(l_req),   32'(m_req));
    chk("bar_mask", 32'(l_mask),  m_req ? (32'd1 << m_hole) : 32'd0);
    chk("pending",  32'(l_pend),  32'(m_pend));
    chk("total",    32'(l_total), 32'(m_total));
    chk("dropped",  32'(l_drop),  32'(m_drop));
    model_edge(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic put_clear(int ln, int cb, bit sp, logic [31:0] r);
    clear_valid = 1'b1;
    lines = 3'(ln); combo_cnt = 8'(cb); t_spin = sp; rng = r;
    step();
    clear_valid = 1'b0;
  endtask

  initial begin
    int n, last, first_c, ndrop, pmax, tb_total;
    bit any, stable;
    logic [9:0] m0;

    reset = 1'b1; clear_valid = 1'b0; lines = '0; combo_cnt = '0;
    t_spin = 1'b0; flush = 1'b0; rng = '0; bif.bar_ack = 1'b0;
    model_clear(0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("rst_req",   32'(l_req),   0);
    chk("rst_mask",  32'(l_mask),  0);
    chk("rst_pend",  32'(l_pend),  0);
    chk("rst_total", 32'(l_total), 0);

    // 4-line clear, ack always high
    bif.bar_ack = 1'b1;
    first_c = cyc;
    put_clear(4, 0, 0, 32'h0000_0003);
    step();
    chk("s36_req_n1", 32'(l_req), 0);
    step();
    chk("s36_req_n2", 32'(l_req), 1);
    chk("s36_lat",    32'(cyc - 1 - first_c), 2);
    chk("s36_mask",   32'(l_mask), 32'h008);
    n = 1; last = cyc - 1;
    repeat (25) begin
      step();
      if (l_req) begin
        chk("s36_space", 32'(cyc - 1 - last), 5);
        chk("s36_mask_r", 32'(l_mask), 32'h008);
        last = cyc - 1;
        n++;
      end
    end
    chk("s36_rows",  32'(n), 4);
    chk("s36_total", 32'(l_total), 4);

    // T-spin double with combo 6, hole 12 -> column 2
    put_clear(2, 6, 1, 32'h0000_000C);
    n = 0;
    repeat (40) begin
      step();
      if (l_req) begin
        chk("s37_mask", 32'(l_mask), 32'h004);
        n++;
      end
    end
    chk("s37_rows",  32'(n), 6);
    chk("s37_total", 32'(l_total), 10);

    // single with no combo: nothing queued, nothing dropped
    put_clear(1, 0, 0, $urandom);
    any = 0;
    repeat (8) begin
      step();
      any |= l_req | l_drop;
    end
    chk("s38_quiet", 32'(any), 0);

    // ack held low: offer stays put, backlog fills, fifth extra batch dropped
    bif.bar_ack = 1'b0;
    put_clear(4, 0, 0, 32'h0000_0005);
    step();
    step();
    chk("s39_req", 32'(l_req), 1);
    chk("s39_mask", 32'(l_mask), 32'h020);
    m0 = l_mask; stable = 1;
    repeat (50) begin
      step();
      if (!l_req || l_mask != m0) stable = 0;
    end
    chk("s39_stable", 32'(stable), 1);
    ndrop = 0; pmax = 0;
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) put_clear(4, 0, 0, $urandom);
      else            step();
      ndrop += int'(l_drop);
      if (int'(l_pend) > pmax) pmax = int'(l_pend);
    end
    repeat (4) begin
      step();
      ndrop += int'(l_drop);
      if (int'(l_pend) > pmax) pmax = int'(l_pend);
    end
    chk("s39_drops", 32'(ndrop), 1);
    chk("s39_pmax",  32'(pmax), 20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("s39_flush_pend", 32'(l_pend), 0);

    // flush during the gap with three rows still pending
    bif.bar_ack = 1'b1;
    put_clear(4, 0, 0, 32'h0000_0007);
    step();
    step();
    bif.bar_ack = 1'b0;
    step();
    chk("s40_pend_gap", 32'(l_pend), 3);
    tb_total = int'(l_total);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("s40_req",   32'(l_req), 0);
    chk("s40_pend",  32'(l_pend), 0);
    chk("s40_total", 32'(l_total), 32'(tb_total));
    any = 0;
    repeat (10) begin step(); any |= l_req; end
    chk("s40_idle", 32'(any), 0);

    // reset coinciding with an ack while offering
    put_clear(4, 0, 0, 32'h0000_0000);
    step();
    step();
    chk("s41_req", 32'(l_req), 1);
    reset = 1'b1; bif.bar_ack = 1'b1;
    step();
    reset = 1'b0; bif.bar_ack = 1'b0;
    step();
    chk("s41_total", 32'(l_total), 0);
    chk("s41_req0",  32'(l_req), 0);
    any = 0;
    repeat (10) begin step(); any |= l_req; end
    chk("s41_idle", 32'(any), 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      clear_valid = ($urandom_range(0, 6) == 0);
      lines       = 3'($urandom_range(1, 4));
      combo_cnt   = 8'($urandom_range(0, 9));
      t_spin      = 1'($urandom_range(0, 1));
      rng         = $urandom;
      bif.bar_ack = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 199) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      step();
    end
    clear_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
